// File: rtl/pll_lock_rst_seq.sv
// pll_lock_rst_seq: turns the raw PLL lock into a qualified, sequenced active-low system reset.
// Define PLL_LOSS_CNT_EN to build the saturating loss-of-lock event counter (loss_cnt_o).
module pll_lock_rst_seq #(
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned LOCK_STABLE_CYCLES = 1260,
   parameter int unsigned RST_HOLD_CYCLES    = 126,
   parameter int unsigned LOSS_CNT_W         = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  pll_lock_i,
   input  logic                  clr_flag_i,
   output logic                  sys_rst_n_o,
   output logic                  sys_ready_o,
   output logic                  lock_lost_o,
   output logic [1:0]            fsm_state_o,
   output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

   localparam int unsigned CNT_MAX = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                     LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);

   localparam logic [1:0] ST_WAIT = 2'd0;
   localparam logic [1:0] ST_QUAL = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_RUN  = 2'd3;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   lock_s;

   logic [1:0]             state_q;
   logic [1:0]             state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic [CNT_W-1:0]       cnt_step_s;
   logic                   loss_evt_s;

   logic                   sys_rst_n_q;
   logic                   sys_rst_n_d;
   logic                   sys_ready_q;
   logic                   sys_ready_d;
   logic                   lock_lost_q;
   logic                   lock_lost_d;

   // Raw lock is asynchronous to clk; only the last synchroniser stage is ever observed.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock_i};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign lock_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d    = state_q;
      cnt_step_s = cnt_q;
      loss_evt_s = 1'b0;
      case (state_q)
         ST_WAIT: begin
            if (lock_s) begin
               state_d = ST_QUAL;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_QUAL: begin
            if (!lock_s) begin
               state_d = ST_WAIT;
            end else if (cnt_q == QUAL_LAST) begin
               state_d = ST_HOLD;
            end else begin
               cnt_step_s = cnt_q + CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (!lock_s) begin
               state_d = ST_WAIT;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = ST_RUN;
            end else begin
               cnt_step_s = cnt_q + CNT_ONE;
            end
         end
         ST_RUN: begin
            if (!lock_s) begin
               state_d    = ST_WAIT;
               loss_evt_s = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_WAIT;
         end
      endcase
   end

   // One shared counter: every state change restarts it, so each timed state starts from zero.
   always_comb begin
      if (state_d != state_q) begin
         cnt_d = CNT_ZERO;
      end else begin
         cnt_d = cnt_step_s;
      end
   end

   always_comb begin
      sys_rst_n_d = (state_d == ST_RUN);
      sys_ready_d = (state_d == ST_RUN);
   end

   // A loss event in the same cycle as clr_flag_i must leave the flag set.
   always_comb begin
      if (loss_evt_s) begin
         lock_lost_d = 1'b1;
      end else if (clr_flag_i) begin
         lock_lost_d = 1'b0;
      end else begin
         lock_lost_d = lock_lost_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_WAIT;
         cnt_q       <= CNT_ZERO;
         sys_rst_n_q <= 1'b0;
         sys_ready_q <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sys_rst_n_q <= sys_rst_n_d;
         sys_ready_q <= sys_ready_d;
         lock_lost_q <= lock_lost_d;
      end
   end

`ifdef PLL_LOSS_CNT_EN
   logic [LOSS_CNT_W-1:0] loss_cnt_q;
   logic [LOSS_CNT_W-1:0] loss_cnt_d;

   // Saturates at all-ones; only rst_ni clears it, clr_flag_i deliberately does not.
   always_comb begin
      if (loss_evt_s && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
         loss_cnt_d = loss_cnt_q + {{(LOSS_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         loss_cnt_d = loss_cnt_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         loss_cnt_q <= {LOSS_CNT_W{1'b0}};
      end else begin
         loss_cnt_q <= loss_cnt_d;
      end
   end

   assign loss_cnt_o = loss_cnt_q;
`else
   assign loss_cnt_o = {LOSS_CNT_W{1'b0}};
`endif

   assign sys_rst_n_o = sys_rst_n_q;
   assign sys_ready_o = sys_ready_q;
   assign lock_lost_o = lock_lost_q;
   assign fsm_state_o = state_q;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed self-checking bench for pll_lock_rst_seq with SYNC=2, STABLE=4, HOLD=3, LOSS_CNT_W=2.
// Expected loss_cnt values follow PLL_LOSS_CNT_EN when it is defined for the build.
module tb_pll_lock_rst_seq;

   localparam int unsigned LCW = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           pll_lock;
   logic           clr_flag;
   logic           sys_rst_n;
   logic           sys_ready;
   logic           lock_lost;
   logic [1:0]     fsm_state;
   logic [LCW-1:0] loss_cnt;

   int checks = 0;
   int errors = 0;

   // fsm_state after edges 1..10 following a lock rise seen from WAIT
   logic [1:0] exp_seq [0:9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};

   pll_lock_rst_seq #(
      .SYNC_STAGES        (2),
      .LOCK_STABLE_CYCLES (4),
      .RST_HOLD_CYCLES    (3),
      .LOSS_CNT_W         (LCW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .pll_lock_i  (pll_lock),
      .clr_flag_i  (clr_flag),
      .sys_rst_n_o (sys_rst_n),
      .sys_ready_o (sys_ready),
      .lock_lost_o (lock_lost),
      .fsm_state_o (fsm_state),
      .loss_cnt_o  (loss_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_loss(input int n);
`ifdef PLL_LOSS_CNT_EN
      return (n > 3) ? 32'd3 : 32'(n);
`else
      return 32'd0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Lock must already be high (and seen from WAIT) before the first edge of this window.
   task automatic run_seq(input string tag);
      for (int e = 0; e < 10; e++) begin
         tick();
         check($sformatf("%s_state_e%0d", tag, e + 1), 32'(fsm_state), 32'(exp_seq[e]));
         check($sformatf("%s_rstn_e%0d", tag, e + 1), 32'(sys_rst_n), (e == 9) ? 32'd1 : 32'd0);
         check($sformatf("%s_ready_e%0d", tag, e + 1), 32'(sys_ready), (e == 9) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic do_loss(input string tag, input int n, input bit with_clr);
      pll_lock = 1'b0;
      tick();
      check({tag, "_rstn_e1"}, 32'(sys_rst_n), 32'd1);
      tick();
      check({tag, "_rstn_e2"}, 32'(sys_rst_n), 32'd1);
      clr_flag = with_clr;
      tick();
      clr_flag = 1'b0;
      check({tag, "_rstn_e3"}, 32'(sys_rst_n), 32'd0);
      check({tag, "_ready_e3"}, 32'(sys_ready), 32'd0);
      check({tag, "_state_e3"}, 32'(fsm_state), 32'd0);
      check({tag, "_lost"}, 32'(lock_lost), 32'd1);
      check({tag, "_losscnt"}, 32'(loss_cnt), exp_loss(n));
   endtask

   initial begin
      rst_n    = 1'b1;
      pll_lock = 1'b0;
      clr_flag = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_state", 32'(fsm_state), 32'd0);
      check("rst_rstn", 32'(sys_rst_n), 32'd0);
      check("rst_ready", 32'(sys_ready), 32'd0);
      check("rst_lost", 32'(lock_lost), 32'd0);
      check("rst_losscnt", 32'(loss_cnt), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // 1: no lock for 20 cycles
      repeat (20) tick();
      check("idle_state", 32'(fsm_state), 32'd0);
      check("idle_rstn", 32'(sys_rst_n), 32'd0);
      check("idle_ready", 32'(sys_ready), 32'd0);

      // 3: glitch during QUALIFY, then 2: full sequence after restore
      pll_lock = 1'b1;
      for (int e = 0; e < 4; e++) begin
         tick();
         check($sformatf("pre_state_e%0d", e + 1), 32'(fsm_state), 32'(exp_seq[e]));
      end
      pll_lock = 1'b0;
      tick();
      check("glitch_state_e5", 32'(fsm_state), 32'd1);
      tick();
      check("glitch_state_e6", 32'(fsm_state), 32'd1);
      pll_lock = 1'b1;
      run_seq("seq1");
      check("seq1_lost", 32'(lock_lost), 32'd0);
      check("seq1_losscnt", 32'(loss_cnt), 32'd0);

      // 4: first loss from RUN
      do_loss("loss1", 1, 1'b0);

      // 5: losses up to saturation, clr interplay
      pll_lock = 1'b1;
      run_seq("seq2");
      do_loss("loss2", 2, 1'b0);
      pll_lock = 1'b1;
      run_seq("seq3");
      do_loss("loss3", 3, 1'b0);
      clr_flag = 1'b1;
      tick();
      clr_flag = 1'b0;
      check("clr_alone1", 32'(lock_lost), 32'd0);
      pll_lock = 1'b1;
      run_seq("seq4");
      do_loss("loss4_clr", 4, 1'b1);
      clr_flag = 1'b1;
      tick();
      clr_flag = 1'b0;
      check("clr_alone2", 32'(lock_lost), 32'd0);
      check("clr_keeps_cnt", 32'(loss_cnt), exp_loss(4));

      // 6: async reset in the middle of HOLD
      pll_lock = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
      end
      check("hold_state", 32'(fsm_state), 32'd2);
      rst_n = 1'b0;
      #1;
      check("arst_state", 32'(fsm_state), 32'd0);
      check("arst_rstn", 32'(sys_rst_n), 32'd0);
      check("arst_ready", 32'(sys_ready), 32'd0);
      check("arst_lost", 32'(lock_lost), 32'd0);
      check("arst_losscnt", 32'(loss_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      run_seq("seq5");
      check("seq5_lost", 32'(lock_lost), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
